// File: rtl/fir_pkg.sv
// Shared FIR stream definitions: buffer FSM state encoding and stream widths.
package fir_pkg;

  localparam int unsigned STREAM_W = 32;  // default sample width on the FIR streams
  localparam int unsigned CNT_W    = 32;  // frame length and beat counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Register-based first-word-fall-through FIFO with an occupancy count.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write
// side; pop_i read side (rdata_o shows the head entry, 0 when empty);
// level_o current occupancy (0..DEPTH). Callers never push when full or pop
// when empty.
module fir_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the empty-mask on rdata_o hides stale contents.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fir_ys_buffer.sv
// Frame-oriented output buffer between the FIR result stream and downstream.
// Ports: axis_clk/axis_rst_n clock and async active-low reset; length and
// frame_start arm a frame of length beats (0 counts as 1); s_* upstream
// AXI-Stream slave; m_* downstream AXI-Stream master with m_tlast on the
// final beat; frame_done one-cycle pulse after the last beat leaves;
// level current FIFO occupancy.
module fir_ys_buffer
  import fir_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = STREAM_W,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [CNT_W-1:0]       length,
  input  logic                   frame_start,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  fir_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [LW-1:0]    fifo_level;
  logic             push, pop, in_last, out_last;

  // Handshakes depend only on registered state and occupancy.
  assign s_tready = (state_q == RUN) && (fifo_level < LW'(DEPTH));
  assign m_tvalid = (fifo_level != '0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign in_last  = (in_cnt_q == len_q - CNT_W'(1));
  assign out_last = (out_cnt_q == len_q - CNT_W'(1));
  assign m_tlast  = m_tvalid && out_last;

  // Frame FSM and beat counters.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    frame_done_d = 1'b0;
    if (push) in_cnt_d  = in_cnt_q + CNT_W'(1);
    if (pop)  out_cnt_d = out_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = RUN;
          len_d     = (length == '0) ? CNT_W'(1) : length;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      RUN: begin
        if (push && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (pop && out_last) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (pDATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (axis_clk),
    .rst_ni  (axis_rst_n),
    .push_i  (push),
    .wdata_i (s_tdata),
    .pop_i   (pop),
    .rdata_o (m_tdata),
    .level_o (fifo_level)
  );

  assign level      = fifo_level;
  assign frame_done = frame_done_q;

endmodule

// File: doc/fir_ys_buffer.md
FIR_YS_BUFFER -- requirements
Module: fir_ys_buffer

Interface
REQ-001 The module SHALL have parameter pDATA_WIDTH, default 32, meaning the sample width.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the FIFO entry count (power of two, at least 2).
REQ-003 The module SHALL have port axis_clk, input, 1 bit, the clock; every register updates on its rising edge.
REQ-004 The module SHALL have port axis_rst_n, input, 1 bit, the reset, asynchronous, active-low.
REQ-005 The module SHALL have port length, input, 32 bits, the frame sample count, sampled on frame_start.
REQ-006 The module SHALL have port frame_start, input, 1 bit, a one-cycle pulse that arms a frame.
REQ-007 The module SHALL have ports s_tvalid (input, 1), s_tdata (input, pDATA_WIDTH) and s_tready (output, 1), forming the upstream AXI-Stream slave fed by the FIR sm_* port.
REQ-008 The module SHALL have ports m_tvalid (output, 1), m_tdata (output, pDATA_WIDTH), m_tlast (output, 1) and m_tready (input, 1), forming the downstream AXI-Stream master.
REQ-009 The module SHALL have port frame_done, output, 1 bit, a one-cycle pulse after the last output beat.
REQ-010 The module SHALL have port level, output, $clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and FLUSH.
REQ-012 FSM transitions SHALL be:
- IDLE->RUN on frame_start.
- RUN->FLUSH on the push that accepts input beat length-1.
- FLUSH->IDLE on the pop of output beat length-1.
REQ-013 frame_start SHALL be ignored outside IDLE.
REQ-014 In IDLE, length SHALL be latched into len_r when frame_start is high; len_r==0 SHALL be treated as 1.
REQ-015 s_tready SHALL equal (state==RUN) && (level<DEPTH), derived from registered count only (no combinational path from m_tready).
REQ-016 A push SHALL occur on s_tvalid && s_tready; a pop SHALL occur on m_tvalid && m_tready.
REQ-017 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-018 The FIFO SHALL be first-word-fall-through:
- m_tvalid = (level!=0).
- m_tdata = the head entry.
- A beat pushed at edge N is visible on m_tdata after edge N when the FIFO was empty (1-cycle latency).
REQ-019 Read and write pointers SHALL wrap modulo DEPTH.
REQ-020 Full SHALL mean level==DEPTH, which blocks push; empty SHALL mean level==0, which drives m_tvalid low.
REQ-021 in_cnt and out_cnt SHALL be 32-bit counters that clear on frame_start and increment on push and pop respectively.
REQ-022 m_tlast SHALL equal m_tvalid && (out_cnt==len_r-1).
REQ-023 frame_done SHALL pulse high for exactly one cycle, in the cycle after the FLUSH->IDLE pop.
REQ-024 m_tdata/m_tlast SHALL remain stable while m_tvalid is high and m_tready is low.
REQ-025 In IDLE, the FIFO SHALL hold no data, because pushes are only possible in RUN and the frame ends empty.

Reset
REQ-026 While axis_rst_n is low, all of the following SHALL hold immediately:
- state=IDLE.
- level=0, both pointers=0.
- in_cnt=out_cnt=0, len_r=0.
- s_tready=0, m_tvalid=0, m_tlast=0, frame_done=0.
REQ-027 m_tdata SHALL read 0 after reset; FIFO storage SHALL need no reset.
REQ-028 Reset asserted mid-frame SHALL discard buffered beats, with no frame_done generated.

Structure
REQ-029 The state encoding (IDLE=0, RUN=1, FLUSH=2) SHALL reside in the shared fir_pkg package, alongside the stream width constant.
REQ-030 Storage plus pointers SHALL be one sub-module, fir_sync_fifo; FSM and counters SHALL stay in the top module.
REQ-031 The FIFO SHALL be register-based, not BRAM.

Verification
REQ-032 Basic frame: frame_start with length=5, push 1..5 with m_tready=1 -> m_tdata 1..5, m_tlast only on 5, frame_done one cycle later, state IDLE.
REQ-033 Backpressure: length=12, DEPTH=8, m_tready=0 -> s_tready drops after 8 pushes, level=8; raise m_tready -> all 12 beats in order, tlast on 12th.
REQ-034 Simultaneous push/pop at level=3 -> level stays 3 across 10 cycles; output order is preserved across the pointer wrap.
REQ-035 length=0 -> a single beat is accepted, m_tlast=1 on it, and the FSM returns to IDLE.
REQ-036 frame_start pulsed during RUN (length=20 vs original 4) -> ignored; tlast on beat 4.
REQ-037 Reset asserted with level=5 in RUN -> level=0, m_tvalid=0, s_tready=0, no frame_done; a new length=2 frame then completes normally.
